// File: rtl/mem_pkg.sv
// Shared types and sizing for the single-port memory subsystem.
package mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } ctrl_state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mem_array.sv
// Storage array: one write or one registered read per enabled cycle, cleared on reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [WORDS];

    // Each word is its own register so the whole array clears with reset.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    mem_reg[gi] <= '0;
                end else if (ce && we && (addr == ADDR_W'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (ce && !we) begin
            rdata <= mem_reg[addr];
        end
    end
endmodule

// File: rtl/mem_subsystem.sv
// Command controller: accepts one read/write in IDLE, drives the array for one
// cycle, then pulses ready_sys for one cycle.
module mem_subsystem
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_sys,
    input  logic              we_sys,
    input  logic [ADDR_W-1:0] addr_sys,
    input  logic [DATA_W-1:0] data_sys_i,
    output logic [DATA_W-1:0] data_sys_o,
    output logic              ready_sys,
    output logic              ce_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    output logic [DATA_W-1:0] datao_mem
);
    ctrl_state_t       state_reg, state_next;
    logic              ce_next, we_next, ready_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] datai_next;
    // we_mem drops before DONE, so the command type is remembered separately.
    logic              op_we_reg, op_we_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ce_mem    <= 1'b0;
            we_mem    <= 1'b0;
            addr_mem  <= '0;
            datai_mem <= '0;
            ready_sys <= 1'b0;
            op_we_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ce_mem    <= ce_next;
            we_mem    <= we_next;
            addr_mem  <= addr_next;
            datai_mem <= datai_next;
            ready_sys <= ready_next;
            op_we_reg <= op_we_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ce_next    = ce_mem;
        we_next    = we_mem;
        addr_next  = addr_mem;
        datai_next = datai_mem;
        ready_next = ready_sys;
        op_we_next = op_we_reg;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b0;
                if (cmd_valid_sys) begin
                    ce_next    = 1'b1;
                    we_next    = we_sys;
                    addr_next  = addr_sys;
                    datai_next = data_sys_i;
                    op_we_next = we_sys;
                    state_next = ACCESS;
                end else begin
                    ce_next = 1'b0;
                    we_next = 1'b0;
                end
            end
            ACCESS: begin
                ce_next    = 1'b0;
                we_next    = 1'b0;
                ready_next = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                ready_next = 1'b0;
                state_next = IDLE;
            end
            default: begin
                ce_next    = 1'b0;
                we_next    = 1'b0;
                ready_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign data_sys_o = (state_reg == DONE && !op_we_reg) ? datao_mem : '0;

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clk),
        .reset(reset),
        .ce   (ce_mem),
        .we   (we_mem),
        .addr (addr_mem),
        .wdata(datai_mem),
        .rdata(datao_mem)
    );
endmodule

// File: tb/tb_mem_subsystem.sv
// Bench for mem_subsystem: directed table, multi-cycle corner sequences and
// random commands checked against a flat array model.
module tb_mem_subsystem;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid_sys = 1'b0;
    logic       we_sys = 1'b0;
    logic [7:0] addr_sys = 8'h00;
    logic [7:0] data_sys_i = 8'h00;
    logic [7:0] data_sys_o;
    logic       ready_sys;
    logic       ce_mem;
    logic       we_mem;
    logic [7:0] addr_mem;
    logic [7:0] datai_mem;
    logic [7:0] datao_mem;

    mem_subsystem dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid_sys(cmd_valid_sys),
        .we_sys       (we_sys),
        .addr_sys     (addr_sys),
        .data_sys_i   (data_sys_i),
        .data_sys_o   (data_sys_o),
        .ready_sys    (ready_sys),
        .ce_mem       (ce_mem),
        .we_mem       (we_mem),
        .addr_mem     (addr_mem),
        .datai_mem    (datai_mem),
        .datao_mem    (datao_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    int         checks = 0;
    int         fails = 0;
    int         ready_pulses = 0;
    int         done_cmds = 0;
    logic [7:0] model [256];
    vec_t       vecs [8];

    always @(posedge clk) if (ready_sys) ready_pulses++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
    endtask

    // One full command with strict latency checks; exp is the read data (0 for writes).
    task automatic do_cmd(input logic we, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp);
        @(negedge clk);
        cmd_valid_sys = 1'b1;
        we_sys        = we;
        addr_sys      = a;
        data_sys_i    = d;
        @(posedge clk); #1;
        chk("accept_ce", int'(ce_mem), 1);
        chk("accept_we", int'(we_mem), int'(we));
        chk("accept_addr", int'(addr_mem), int'(a));
        if (we) chk("accept_wdata", int'(datai_mem), int'(d));
        cmd_valid_sys = 1'b0;
        @(posedge clk); #1;
        chk("done_ready", int'(ready_sys), 1);
        chk("done_ce", int'(ce_mem), 0);
        chk("done_data", int'(data_sys_o), int'(exp));
        @(posedge clk); #1;
        chk("idle_ready", int'(ready_sys), 0);
        done_cmds++;
        if (we) model[a] = d;
        $display("cmd we=%0d addr=0x%02h wdata=0x%02h rdata=0x%02h exp=0x%02h",
                 we, a, d, data_sys_o, exp);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h3C, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h3C, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 8'h00, 8'h11, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 8'hEE, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h11};
        vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'hEE};
        vecs[6] = '{1'b0, 8'h01, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 8'hFE, 8'h00, 8'h00};

        // Reset
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready_sys), 0);
        chk("rst_ce", int'(ce_mem), 0);
        chk("rst_data_sys_o", int'(data_sys_o), 0);
        chk("rst_datao_mem", int'(datao_mem), 0);
        @(negedge clk);
        reset = 1'b1;
        do_cmd(1'b0, 8'h00, 8'h00, 8'h00);

        // Directed table
        for (int i = 0; i < 8; i++) do_cmd(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp);

        // Busy ignore: command inputs change and stay valid through ACCESS/DONE
        @(negedge clk);
        cmd_valid_sys = 1'b1; we_sys = 1'b1; addr_sys = 8'h10; data_sys_i = 8'h55;
        @(posedge clk); #1;
        chk("busy_accept_ce", int'(ce_mem), 1);
        addr_sys = 8'h20; data_sys_i = 8'h77;
        @(posedge clk); #1;
        chk("busy_ready", int'(ready_sys), 1);
        chk("busy_addr_hold", int'(addr_mem), 8'h10);
        @(posedge clk); #1;
        chk("busy_done_ignored_ce", int'(ce_mem), 0);
        chk("busy_ready_low", int'(ready_sys), 0);
        cmd_valid_sys = 1'b0;
        @(posedge clk); #1;
        chk("busy_idle_ce", int'(ce_mem), 0);
        done_cmds++;
        model[8'h10] = 8'h55;
        $display("cmd busy write addr=0x10 wdata=0x55 (0x20 presented while busy)");
        do_cmd(1'b0, 8'h20, 8'h00, 8'h00);
        do_cmd(1'b0, 8'h10, 8'h00, 8'h55);

        // Back-to-back: write then read held valid, read accepted at the first IDLE edge
        @(negedge clk);
        cmd_valid_sys = 1'b1; we_sys = 1'b1; addr_sys = 8'h80; data_sys_i = 8'hC3;
        @(posedge clk); #1;
        chk("b2b_wr_ce", int'(ce_mem), 1);
        we_sys = 1'b0;
        @(posedge clk); #1;
        chk("b2b_wr_ready", int'(ready_sys), 1);
        @(posedge clk); #1;
        chk("b2b_gap_ce", int'(ce_mem), 0);
        chk("b2b_gap_ready", int'(ready_sys), 0);
        @(posedge clk); #1;
        chk("b2b_rd_ce", int'(ce_mem), 1);
        chk("b2b_rd_we", int'(we_mem), 0);
        cmd_valid_sys = 1'b0;
        @(posedge clk); #1;
        chk("b2b_rd_ready", int'(ready_sys), 1);
        chk("b2b_rd_data", int'(data_sys_o), 8'hC3);
        @(posedge clk); #1;
        chk("b2b_rd_ready_low", int'(ready_sys), 0);
        done_cmds += 2;
        model[8'h80] = 8'hC3;
        $display("cmd b2b write/read addr=0x80 rdata=0x%02h exp=0xc3", datao_mem);

        // Reset during ACCESS aborts the write and clears the array
        @(negedge clk);
        cmd_valid_sys = 1'b1; we_sys = 1'b1; addr_sys = 8'h40; data_sys_i = 8'h99;
        @(posedge clk); #1;
        chk("rstmid_ce", int'(ce_mem), 1);
        cmd_valid_sys = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rstmid_ce_cleared", int'(ce_mem), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rstmid_no_ready", int'(ready_sys), 0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        $display("cmd reset mid-write addr=0x40 aborted");
        do_cmd(1'b0, 8'h40, 8'h00, 8'h00);
        do_cmd(1'b0, 8'h3C, 8'h00, 8'h00);

        // Random commands against the array model
        for (int n = 0; n < 60; n++) begin
            logic       w;
            logic [7:0] a, d;
            w = 1'($urandom_range(0, 1));
            a = (n % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            do_cmd(w, a, d, w ? 8'h00 : model[a]);
        end

        chk("ready_pulse_count", ready_pulses, done_cmds);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
